// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with iterative MUL/DIV into HI/LO and a start/busy/done handshake
module alu_seq #(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [3:0]    opcode_i,
  input  logic [W-1:0]  rsval_i,
  input  logic [W-1:0]  rtval_i,
  input  logic [SW-1:0] shamt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [W-1:0]  rdval_o,
  output logic          zero_o,
  output logic          carry_o,
  output logic          div0_o,
  output logic [W-1:0]  hi_o,
  output logic [W-1:0]  lo_o
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]  b_q, b_d;
  logic          is_div_q, is_div_d;
  logic [W-1:0]  rdval_q, rdval_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          div0_q, div0_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic [W:0]    add_sum, sub_diff;
  logic [W-1:0]  sc_res;
  logic          sc_carry;

  always_comb begin
    add_sum  = {1'b0, rsval_i} + {1'b0, rtval_i};
    sub_diff = {1'b0, rsval_i} - {1'b0, rtval_i};
    sc_res   = '0;
    sc_carry = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        sc_res   = add_sum[W-1:0];
        sc_carry = add_sum[W];
      end
      OP_SUB: begin
        sc_res   = sub_diff[W-1:0];
        sc_carry = sub_diff[W];
      end
      OP_SLL:  sc_res = rsval_i << shamt_i;
      OP_SRL:  sc_res = rsval_i >> shamt_i;
      OP_SRA:  sc_res = $unsigned($signed(rsval_i) >>> shamt_i);
      OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(rsval_i) < $signed(rtval_i))};
      OP_OR:   sc_res = rsval_i | rtval_i;
      OP_AND:  sc_res = rsval_i & rtval_i;
      OP_XOR:  sc_res = rsval_i ^ rtval_i;
      OP_MFLO: sc_res = lo_q;
      OP_MFHI: sc_res = hi_q;
      default: sc_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV,
  // so both finish with HI in the upper half and LO in the lower half.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_rem;
  logic [W-1:0]   div_sub;
  logic [W-1:0]   div_r;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
    div_rem  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge   = (div_rem >= {1'b0, b_q});
    div_sub  = div_rem[W-1:0] - b_q;
    div_r    = div_ge ? div_sub : div_rem[W-1:0];
    div_next = {div_r, acc_q[W-2:0], div_ge};
  end

  logic accept;
  logic is_multi;

  assign accept   = start_i && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign is_multi = (opcode_i == OP_MUL) || (opcode_i == OP_DIV);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    rdval_d  = rdval_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = acc_q[2*W-1:W];
        lo_d    = acc_q[W-1:0];
        rdval_d = acc_q[W-1:0];
        zero_d  = (acc_q[W-1:0] == '0);
        carry_d = 1'b0;
        div0_d  = is_div_q && (b_q == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // A single-cycle op chained onto FIN sees the pre-update HI/LO and owns rdval/flags.
    if (accept) begin
      if (is_multi) begin
        cnt_d    = CW'(W);
        is_div_d = (opcode_i == OP_DIV);
        if (opcode_i == OP_MUL) begin
          state_d = S_MUL;
          acc_d   = {{W{1'b0}}, rtval_i};
          b_d     = rsval_i;
        end else begin
          state_d = S_DIV;
          acc_d   = {{W{1'b0}}, rsval_i};
          b_d     = rtval_i;
        end
      end else begin
        rdval_d = sc_res;
        zero_d  = (sc_res == '0);
        carry_d = sc_carry;
        div0_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      rdval_q  <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      rdval_q  <= rdval_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign rdval_o = rdval_q;
  assign zero_o  = zero_q;
  assign carry_o = carry_q;
  assign div0_o  = div0_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (table vectors, scoreboard, multi-cycle sequences)
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] rsval, rtval;
  logic [3:0]  shamt;
  logic        busy, done, zero, carry, div0;
  logic [15:0] rdval, hi, lo;

  logic        s8_start;
  logic [3:0]  s8_op;
  logic [7:0]  s8_a, s8_b;
  logic [2:0]  s8_sh;
  logic        s8_busy, s8_done, s8_zero, s8_carry, s8_div0;
  logic [7:0]  s8_rd, s8_hi, s8_lo;

  always #5 clk = ~clk;

  alu_seq #(.W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .opcode_i(opcode),
    .rsval_i(rsval), .rtval_i(rtval), .shamt_i(shamt),
    .busy_o(busy), .done_o(done), .rdval_o(rdval), .zero_o(zero),
    .carry_o(carry), .div0_o(div0), .hi_o(hi), .lo_o(lo)
  );

  alu_seq #(.W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s8_start), .opcode_i(s8_op),
    .rsval_i(s8_a), .rtval_i(s8_b), .shamt_i(s8_sh),
    .busy_o(s8_busy), .done_o(s8_done), .rdval_o(s8_rd), .zero_o(s8_zero),
    .carry_o(s8_carry), .div0_o(s8_div0), .hi_o(s8_hi), .lo_o(s8_lo)
  );

  typedef struct {
    logic [15:0] rdval;
    logic        zero;
    logic        carry;
    logic        div0;
    logic [15:0] hi;
    logic [15:0] lo;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] rd;
    logic        z;
    logic        c;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[15];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [15:0] m_hi = 16'h0;
  logic [15:0] m_lo = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 rdval=0x%0h, expected no done", rdval);
      end else begin
        e = sb.pop_front();
        chk("sb_rdval", {16'h0, rdval}, {16'h0, e.rdval});
        chk("sb_zero",  {31'h0, zero},  {31'h0, e.zero});
        chk("sb_carry", {31'h0, carry}, {31'h0, e.carry});
        chk("sb_div0",  {31'h0, div0},  {31'h0, e.div0});
        chk("sb_hi",    {16'h0, hi},    {16'h0, e.hi});
        chk("sb_lo",    {16'h0, lo},    {16'h0, e.lo});
      end
    end
  end

  task automatic push_single(input logic [15:0] rd, input logic z, input logic c);
    sb.push_back('{rd, z, c, 1'b0, m_hi, m_lo});
  endtask

  task automatic push_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    m_hi = p[31:16];
    m_lo = p[15:0];
    sb.push_back('{m_lo, (m_lo == 16'h0), 1'b0, 1'b0, m_hi, m_lo});
  endtask

  task automatic push_div(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h0) begin
      m_lo = 16'hFFFF;
      m_hi = a;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
    sb.push_back('{m_lo, (m_lo == 16'h0), 1'b0, (b == 16'h0), m_hi, m_lo});
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    @(negedge clk);
    start = 1'b1; opcode = op; rsval = a; rtval = b; shamt = sh;
    @(posedge clk);
    #1;
    start = 1'b0;
    rsval = 16'($urandom);
    rtval = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, (t >= 200) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time budget");
    $fatal(1);
  end

  initial begin
    int c;
    int nd;

    tbl[0]  = '{4'd0,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{4'd5,  16'h0003, 16'h0005, 4'd0,  16'hFFFE, 1'b0, 1'b1};
    tbl[2]  = '{4'd10, 16'hFFFF, 16'h0001, 4'd0,  16'h0001, 1'b0, 1'b0};
    tbl[3]  = '{4'd1,  16'h8421, 16'h0000, 4'd4,  16'h4210, 1'b0, 1'b0};
    tbl[4]  = '{4'd2,  16'h8421, 16'h0000, 4'd4,  16'h0842, 1'b0, 1'b0};
    tbl[5]  = '{4'd9,  16'h8421, 16'h0000, 4'd4,  16'hF842, 1'b0, 1'b0};
    tbl[6]  = '{4'd1,  16'h0001, 16'h0000, 4'd15, 16'h8000, 1'b0, 1'b0};
    tbl[7]  = '{4'd6,  16'h00F0, 16'h0F0F, 4'd0,  16'h0FFF, 1'b0, 1'b0};
    tbl[8]  = '{4'd7,  16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 1'b0, 1'b0};
    tbl[9]  = '{4'd8,  16'hAAAA, 16'hFFFF, 4'd0,  16'h5555, 1'b0, 1'b0};
    tbl[10] = '{4'd0,  16'h1234, 16'h1111, 4'd0,  16'h2345, 1'b0, 1'b0};
    tbl[11] = '{4'd5,  16'h0005, 16'h0005, 4'd0,  16'h0000, 1'b1, 1'b0};
    tbl[12] = '{4'd10, 16'h0001, 16'hFFFF, 4'd0,  16'h0000, 1'b1, 1'b0};
    tbl[13] = '{4'd13, 16'h1234, 16'h5678, 4'd3,  16'h0000, 1'b1, 1'b0};
    tbl[14] = '{4'd9,  16'h7000, 16'h0000, 4'd4,  16'h0700, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; opcode = 4'd0; rsval = 16'h0; rtval = 16'h0; shamt = 4'd0;
    s8_start = 1'b0; s8_op = 4'd0; s8_a = 8'h0; s8_b = 8'h0; s8_sh = 3'd0;

    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'h0, busy},  32'h0);
    chk("rst_done",  {31'h0, done},  32'h0);
    chk("rst_rdval", {16'h0, rdval}, 32'h0);
    chk("rst_zero",  {31'h0, zero},  32'h0);
    chk("rst_carry", {31'h0, carry}, 32'h0);
    chk("rst_div0",  {31'h0, div0},  32'h0);
    chk("rst_hi",    {16'h0, hi},    32'h0);
    chk("rst_lo",    {16'h0, lo},    32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      push_single(tbl[i].rd, tbl[i].z, tbl[i].c);
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh);
    end
    wait_idle("table_drain");

    push_single(16'h0002, 1'b0, 1'b0);
    issue(4'd0, 16'h0001, 16'h0001, 4'd0);
    @(negedge clk);
    chk("add_done_e1", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk("add_done_e2", {31'h0, done}, 32'h0);

    push_mul(16'hFFFF, 16'hFFFF);
    issue(4'd3, 16'hFFFF, 16'hFFFF, 4'd0);
    c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      if (busy) c++;
    end
    chk("mul_busy_cycles", c, 32'd17);
    chk("mul_done_at_end", {31'h0, done}, 32'h1);
    chk("mul_lo_const", {16'h0, lo}, 32'h0001);
    chk("mul_hi_const", {16'h0, hi}, 32'hFFFE);
    wait_idle("mul_drain");
    push_single(m_hi, 1'b0, 1'b0);
    issue(4'd12, 16'h0, 16'h0, 4'd0);
    wait_idle("mfhi_drain");

    nd = n_done;
    push_div(16'd100, 16'd7);
    issue(4'd4, 16'd100, 16'd7, 4'd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; opcode = 4'd0; rsval = 16'h0BAD; rtval = 16'h0001;
      end else if (k == 17) begin
        chk("div_busy_before_fall", {31'h0, busy}, 32'h1);
        push_div(16'h1234, 16'h0000);
        start = 1'b1; opcode = 4'd4; rsval = 16'h1234; rtval = 16'h0000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k != 17) begin
        rsval = 16'($urandom);
        rtval = 16'($urandom);
      end
    end
    wait_idle("div_chain_drain");
    chk("div_chain_dones", n_done - nd, 32'd2);
    push_single(16'h0003, 1'b0, 1'b0);
    issue(4'd0, 16'h0001, 16'h0002, 4'd0);
    push_single(m_lo, (m_lo == 16'h0), 1'b0);
    issue(4'd11, 16'h0, 16'h0, 4'd0);
    wait_idle("div0_clear_drain");

    push_mul(16'h0003, 16'h0005);
    issue(4'd3, 16'h0003, 16'h0005, 4'd0);
    wait_idle("mul_pre_abort_drain");
    nd = n_done;
    issue(4'd3, 16'h1234, 16'h0100, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_hi = 16'h0;
    m_lo = 16'h0;
    #1;
    chk("abort_busy",  {31'h0, busy},  32'h0);
    chk("abort_hi",    {16'h0, hi},    32'h0);
    chk("abort_lo",    {16'h0, lo},    32'h0);
    chk("abort_rdval", {16'h0, rdval}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_done", n_done - nd, 32'd0);
    push_single(16'h0000, 1'b1, 1'b0);
    issue(4'd11, 16'h0, 16'h0, 4'd0);
    wait_idle("abort_mflo_drain");

    @(negedge clk);
    s8_start = 1'b1; s8_op = 4'd3; s8_a = 8'hFF; s8_b = 8'hFF;
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    c = 0;
    while (s8_busy && c < 100) begin
      @(negedge clk);
      if (s8_busy) c++;
    end
    chk("w8_busy_cycles", c, 32'd9);
    chk("w8_done", {31'h0, s8_done}, 32'h1);
    chk("w8_hi",   {24'h0, s8_hi},   32'hFE);
    chk("w8_lo",   {24'h0, s8_lo},   32'h01);
    chk("w8_rd",   {24'h0, s8_rd},   32'h01);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that takes over from the single-cycle datapath ALU in the 16-bit processor. It executes add/sub/logic/shift operations in one cycle, and multiply/divide iteratively over W cycles into architected HI/LO registers. All results are registered and framed by a start/busy/done handshake, so the control unit stalls on busy instead of relying on combinational settling. It sits between the register-file read ports and the writeback mux.

## Interface
- W, 16, operand/result width (≥4, even)
- SW, $clog2(W), shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  operation request; sampled only when busy=0
- opcode  in  4  operation select, sampled with start
- rsval  in  W  operand A, sampled with start
- rtval  in  W  operand B, sampled with start
- shamt  in  SW  shift amount, sampled with start
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: rdval/flags valid
- rdval  out  W  registered result, held until next done
- zero  out  1  rdval==0, updated with done
- carry  out  1  ADD carry-out / SUB borrow; 0 for other ops
- div0  out  1  last DIV had rtval==0; cleared by next done
- hi  out  W  HI register
- lo  out  W  LO register

## Operation
- Opcodes, unsigned unless stated:
  - 0 ADD
  - 1 SLL by shamt
  - 2 SRL by shamt
  - 3 MUL: {HI,LO} = rsval*rtval (2W bits); rdval = low W bits
  - 4 DIV: LO = quotient, HI = remainder; rdval = quotient
  - 5 SUB: rsval-rtval mod 2^W
  - 6 OR
  - 7 AND
  - 8 XOR
  - 9 SRA (arithmetic, sign = rsval[W-1])
  - 10 SLT: signed rsval<rtval → 1, else 0
  - 11 MFLO: rdval = LO
  - 12 MFHI: rdval = HI
  - 13–15 reserved: rdval = 0, done pulses normally
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE & start & op∈{3,4} → MUL/DIV. Latch operands, counter = W, busy = 1.
  - IDLE & start & other op → result registered at the same edge, done = 1 in the next cycle. The FSM stays in IDLE.
  - MUL: shift-add, one multiplier bit per cycle, with a 2W-bit accumulator. The counter decrements each cycle; at 1 → FIN.
  - DIV: restoring shift-subtract, one quotient bit per cycle. At counter 1 → FIN.
  - FIN: write HI, LO, rdval and flags; done = 1; busy = 0 → IDLE.
- start while busy=1 is ignored; no queueing. The operand inputs may change freely while busy.
- DIV by zero: quotient = all ones, remainder = rsval, div0 = 1. It takes the same latency as a normal DIV.
- HI/LO change only on MUL/DIV completion. Single-cycle ops never alter them.
- carry: ADD gives the carry-out of the W-bit sum. SUB gives 1 when rsval<rtval unsigned.
- Reset (rst=0, any time, including mid-MUL/DIV):
  - FSM → IDLE.
  - rdval, hi, lo, counter, accumulator all set to 0.
  - busy, done, zero, carry, div0 set to 0. zero resets to 0 by definition, not by recomputation.
  - An aborted operation produces no done and leaves no HI/LO update.

## Timing
- Edge E0 samples start=1 with busy=0.
- Single-cycle op: rdval/flags update at E0, done high for the cycle E0→E1. Back-to-back single-cycle ops are allowed every cycle.
- MUL/DIV:
  - busy is high from E0 until E(W+1).
  - HI/LO/rdval update at E(W+1); done is high for the cycle E(W+1)→E(W+2).
  - Latency is W+1 cycles; W=16 gives 17.
- A new start may be sampled at E(W+1), the same edge busy falls. It overlaps done without conflict.
- done is never high for two consecutive cycles from a single request.
- MFLO/MFHI issued at E(W+1) read the old HI/LO. One issued at E(W+2) or later reads the new values.

## Test plan
- Reset mid-MUL: start MUL 0x1234*0x0100, pull rst low at E5 → busy=0, done never pulses, hi=lo=rdval=0. After release, MFLO → rdval=0.
- ADD 0xFFFF+0x0001 → rdval=0x0000, zero=1, carry=1, done at E0+1. SUB 0x0003-0x0005 → 0xFFFE, carry=1. SLT 0xFFFF,0x0001 → 1.
- MUL 0xFFFF*0xFFFF → busy 17 cycles, lo=0x0001, hi=0xFFFE, rdval=0x0001. Then MFHI → rdval=0xFFFE.
- DIV 100/7 → lo=14, hi=2, rdval=14. DIV 0x1234/0 → lo=0xFFFF, hi=0x1234, div0=1. A following ADD clears div0.
- Shifts with shamt=4, rsval=0x8421:
  - SLL → 0x4210
  - SRL → 0x0842
  - SRA → 0xF842
  - shamt=15 SLL of 0x0001 → 0x8000
- start pulsed at E3 during a DIV → ignored, exactly one done. A new start at the busy-falling edge is accepted. Repeat with W=8, MUL 0xFF*0xFF → hi=0xFE, lo=0x01, 9-cycle latency.
